// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, field positions, loader error codes and loader states.
// The main control decoder imports the same opcode constants.
package isa_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b0010;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int REG_W   = 3;
  localparam int IMM_W   = 6;
  localparam int JADDR_W = 12;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_BADOP = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: validates the opcode and assembles the 16-bit word.
// Fields the selected format does not use are ignored.
module instr_pack
  import isa_pkg::*;
(
  input  logic [3:0]         i_op,
  input  logic [REG_W-1:0]   i_rs,
  input  logic [REG_W-1:0]   i_rt,
  input  logic [REG_W-1:0]   i_rd,
  input  logic [REG_W-1:0]   i_funct,
  input  logic [IMM_W-1:0]   i_imm,
  input  logic [JADDR_W-1:0] i_addr,
  output logic               o_valid_op,
  output logic [15:0]        o_word
);

  always_comb begin
    o_valid_op = 1'b1;
    o_word     = 16'h0000;
    case (i_op)
      OP_RTYPE:                      o_word = {i_op, i_rs, i_rt, i_rd, i_funct};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: o_word = {i_op, i_rs, i_rt, i_imm};
      OP_J:                          o_word = {i_op, i_addr};
      default:                       o_valid_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test loader front end: accepts field bundles over valid/ready, packs them and
// writes them to consecutive imem addresses, reporting done/err as session status.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int IMEM_AW = 6,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] start_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [2:0]         in_rs,
  input  logic [2:0]         in_rt,
  input  logic [2:0]         in_rd,
  input  logic [2:0]         in_funct,
  input  logic [5:0]         in_imm,
  input  logic [11:0]        in_addr,
  input  logic               in_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [3:0]         err_op,
  output logic [IMEM_AW:0]   word_count
);

  // Handshake: a bundle is consumed on any cycle with in_valid && in_ready;
  // in_ready depends only on state (high throughout LOAD), never on in_valid.

  enc_state_e         r_state, w_state_nxt;
  logic [IMEM_AW-1:0] r_addr;
  logic               r_wrapped;
  logic               r_we;
  logic [IMEM_AW-1:0] r_imem_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [1:0]         r_err_code;
  logic [3:0]         r_err_op;
  logic [IMEM_AW:0]   r_word_count;

  logic               w_valid_op;
  logic [15:0]        w_word;
  logic               w_accept;
  logic               w_write;
  logic               w_enter;

  instr_pack u_pack (
    .i_op       (in_op),
    .i_rs       (in_rs),
    .i_rt       (in_rt),
    .i_rd       (in_rd),
    .i_funct    (in_funct),
    .i_imm      (in_imm),
    .i_addr     (in_addr),
    .o_valid_op (w_valid_op),
    .o_word     (w_word)
  );

  assign w_accept = in_valid && (r_state == ST_LOAD);
  assign w_write  = w_accept && w_valid_op && !r_wrapped;
  assign w_enter  = start && (r_state != ST_LOAD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Bad opcode is checked before overflow and before in_last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (!w_valid_op)   w_state_nxt = ST_ERR;
          else if (r_wrapped) w_state_nxt = ST_ERR;
          else if (in_last)  w_state_nxt = ST_DONE;
        end
      end
      default: if (start) w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_wrapped    <= 1'b0;
      r_we         <= 1'b0;
      r_imem_addr  <= '0;
      r_wdata      <= '0;
      r_err_code   <= ERR_NONE;
      r_err_op     <= 4'h0;
      r_word_count <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_enter) begin
        r_addr       <= start_addr;
        r_wrapped    <= 1'b0;
        r_err_code   <= ERR_NONE;
        r_err_op     <= 4'h0;
        r_word_count <= '0;
      end else if (w_write) begin
        r_we         <= 1'b1;
        r_imem_addr  <= r_addr;
        r_wdata      <= w_word;
        r_addr       <= r_addr + 1'b1;
        r_word_count <= r_word_count + 1'b1;
        if (&r_addr) r_wrapped <= 1'b1;
      end else if (w_accept && !w_valid_op) begin
        r_err_code <= ERR_BADOP;
        r_err_op   <= in_op;
      end else if (w_accept) begin
        r_err_code <= ERR_OVF;
      end
    end
  end

  assign in_ready   = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign imem_we    = r_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_wdata;
  assign err_code   = r_err_code;
  assign err_op     = r_err_op;
  assign word_count = r_word_count;

endmodule
